// File: rtl/alu_mul_sequencer_if.sv
// Request/response and ALU-drive bundle between the execute stage and the
// shift-add multiply sequencer.
interface alu_mul_sequencer_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] product;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] alu_result;

    // Execute-stage side: issues requests, owns the ALU, observes results.
    modport master (
        output start, op_a, op_b, alu_result,
        input  busy, done, product, alu_a, alu_b, alu_op
    );

    // Sequencer side.
    modport slave (
        input  start, op_a, op_b, alu_result,
        output busy, done, product, alu_a, alu_b, alu_op
    );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Unsigned WIDTHxWIDTH multiply (low WIDTH bits) built from repeated ALU add and
// shift-left operations, one ALU operation per cycle, with early exit.
module alu_mul_sequencer #(
    parameter int         WIDTH  = 64,
    parameter logic [3:0] OP_ADD = 4'b0010,
    parameter logic [3:0] OP_SHL = 4'b0111
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_mul_sequencer_if.slave  bus
);
    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [6:0] CNT_LAST = 7'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_SHIFT,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [6:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] product_q, product_d;

    logic [WIDTH-1:0] alu_a_c;
    logic [WIDTH-1:0] alu_b_c;
    logic [3:0]       alu_op_c;

    // NOTE: every register, including the datapath, is cleared by the async
    // reset so an aborted multiply leaves no stale operands or product behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            m_q       <= '0;
            q_q       <= '0;
            p_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from the
            // same pre-edge values, independent of statement order.
            state_q   <= state_d;
            m_q       <= m_d;
            q_q       <= q_d;
            p_q       <= p_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output (no latches).
        state_d   = state_q;
        m_d       = m_q;
        q_d       = q_q;
        p_d       = p_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        alu_a_c   = '0;
        alu_b_c   = '0;
        alu_op_c  = OP_NOP;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    m_d   = bus.op_a;
                    q_d   = bus.op_b;
                    p_d   = '0;
                    cnt_d = '0;
                    if (bus.op_b == '0)
                        state_d = S_DONE;
                    else if (bus.op_b[0])
                        state_d = S_ADD;
                    else
                        state_d = S_SHIFT;
                end
            end

            S_ADD: begin
                alu_a_c  = p_q;
                alu_b_c  = m_q;
                alu_op_c = OP_ADD;
                p_d      = bus.alu_result;
                state_d  = S_SHIFT;
            end

            S_SHIFT: begin
                alu_a_c  = m_q;
                alu_b_c  = WIDTH'(1);
                alu_op_c = OP_SHL;
                m_d      = bus.alu_result;
                q_d      = q_q >> 1;
                cnt_d    = cnt_q + 7'd1;
                // Q[1] is the bit that becomes Q[0] after this shift.
                if ((q_q >> 1) == '0 || cnt_q == CNT_LAST)
                    state_d = S_DONE;
                else if (q_q[1])
                    state_d = S_ADD;
                else
                    state_d = S_SHIFT;
            end

            S_DONE: begin
                product_d = p_q;
                state_d   = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy    = (state_q != S_IDLE);
    assign bus.done    = (state_q == S_DONE);
    assign bus.product = product_q;
    assign bus.alu_a   = alu_a_c;
    assign bus.alu_b   = alu_b_c;
    assign bus.alu_op  = alu_op_c;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer: behavioural ALU, vector table for
// product/latency/op count, plus hand sequences for trace, ignore and reset.
module tb_alu_mul_sequencer;
    localparam int         W      = 64;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SHL = 4'b0111;
    localparam int         LIMIT  = 300;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    alu_mul_sequencer_if #(.WIDTH(W)) bus ();

    alu_mul_sequencer #(.WIDTH(W), .OP_ADD(OP_ADD), .OP_SHL(OP_SHL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural 64-bit ALU: only the two opcodes the sequencer uses.
    assign bus.alu_result = (bus.alu_op == OP_ADD) ? bus.alu_a + bus.alu_b :
                            (bus.alu_op == OP_SHL) ? bus.alu_a << bus.alu_b[5:0] :
                            '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU operations issued while busy, sampled mid-cycle.
    logic [3:0] op_log[$];
    always @(negedge clk) begin
        if (rst_n && bus.busy && bus.alu_op != 4'b0000)
            op_log.push_back(bus.alu_op);
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_product;
        int           exp_latency;
        int           exp_ops;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Issue one request and wait for done; lat counts edges from the accepting
    // edge (1) up to the edge after which done is seen high.
    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] prod, output int lat);
        @(negedge clk);
        op_log.delete();
        bus.start = 1'b1;
        bus.op_a  = a;
        bus.op_b  = b;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            bus.start = 1'b0;
        end while (!bus.done && lat < LIMIT);
        check("done_within_limit", 64'(bus.done), 64'd1);
        @(posedge clk);
        #1;
        prod = bus.product;
    endtask

    logic [W-1:0] prod;
    int           lat;
    logic [19:0]  trace;
    logic         done_seen;

    initial begin
        checks = 0;
        errors = 0;

        vecs[0] = '{64'd3, 64'd5, 64'd15, 6, 5};
        vecs[1] = '{64'h1234, 64'd0, 64'd0, 1, 0};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 4, 3};
        vecs[3] = '{64'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 66, 65};
        vecs[4] = '{64'd0, 64'd7, 64'd0, 7, 6};
        vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 129, 128};
        vecs[6] = '{64'd12345, 64'd1, 64'd12345, 3, 2};

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        #12;
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_product", bus.product, 64'd0);
        check("reset_alu_op", 64'(bus.alu_op), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run(vecs[i].a, vecs[i].b, prod, lat);
            check($sformatf("vec%0d_product", i), prod, vecs[i].exp_product);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_latency));
            check($sformatf("vec%0d_op_count", i), 64'(op_log.size()), 64'(vecs[i].exp_ops));
            check($sformatf("vec%0d_idle_after", i), 64'(bus.busy), 64'd0);
        end

        // 3*5: exact ALU opcode order.
        run(64'd3, 64'd5, prod, lat);
        trace = '0;
        for (int k = 0; k < op_log.size() && k < 5; k++)
            trace = {trace[15:0], op_log[k]};
        check("trace_3x5", 64'(trace), 64'({OP_ADD, OP_SHL, OP_SHL, OP_ADD, OP_SHL}));

        // 7*9 with a second start pulsed while busy: must be ignored.
        @(negedge clk);
        op_log.delete();
        bus.start = 1'b1;
        bus.op_a  = 64'd7;
        bus.op_b  = 64'd9;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 1;
        check("ignore_busy_after_start", 64'(bus.busy), 64'd1);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op_a  = 64'd1;
        bus.op_b  = 64'd1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat++;
        while (!bus.done && lat < LIMIT) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("ignore_latency", 64'(lat), 64'd7);
        @(posedge clk);
        #1;
        check("ignore_product", bus.product, 64'd63);
        check("ignore_no_restart", 64'(bus.busy), 64'd0);
        run(64'd1, 64'd1, prod, lat);
        check("after_ignore_product", prod, 64'd1);
        check("after_ignore_latency", 64'(lat), 64'd3);

        // 5*0xFF aborted by reset after four edges.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op_a  = 64'd5;
        bus.op_b  = 64'hFF;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_product", bus.product, 64'd0);
        check("abort_alu_a", bus.alu_a, 64'd0);
        check("abort_alu_b", bus.alu_b, 64'd0);
        check("abort_alu_op", 64'(bus.alu_op), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done || bus.busy) done_seen = 1'b1;
        end
        check("abort_stays_idle", 64'(done_seen), 64'd0);
        check("abort_product_held", bus.product, 64'd0);
        run(64'd2, 64'd3, prod, lat);
        check("post_reset_product", prod, 64'd6);
        check("post_reset_latency", 64'(lat), 64'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_mul_sequencer.md
# alu_mul_sequencer

Multi-cycle sequencer that computes the low 64 bits of an unsigned 64x64 product by driving the shared 64-bit ALU with repeated add (4'b0010) and shift-left (4'b0111) operations. It sits beside the ALU in the execute stage and owns the ALU input mux whenever `busy` is high. Multiplication is shift-add, one ALU operation per cycle, with early termination once the remaining multiplier bits are zero.

## Interface
- `WIDTH`, 64, operand/product width; must equal the ALU width
- `OP_ADD`, 4'b0010, ALU opcode for add
- `OP_SHL`, 4'b0111, ALU opcode for shift-left
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request; sampled only in IDLE
- `op_a`  in  WIDTH  multiplicand, captured on accepted start
- `op_b`  in  WIDTH  multiplier, captured on accepted start
- `busy`  out  1  high from the cycle after accepted start through the DONE cycle
- `done`  out  1  one-cycle pulse; `product` valid
- `product`  out  WIDTH  result register, held until next accepted start
- `alu_a`  out  WIDTH  ALU operand a
- `alu_b`  out  WIDTH  ALU operand b
- `alu_op`  out  4  ALU opcode
- `alu_result`  in  WIDTH  ALU combinational result

## Operation
- Internal registers: M (multiplicand), Q (multiplier), P (accumulator), cnt (7-bit iteration count).
- States: IDLE, ADD, SHIFT, DONE.
- IDLE: `start`=1 loads M=op_a, Q=op_b, P=0, cnt=0; next state DONE if op_b==0, ADD if op_b[0]==1, else SHIFT. `start`=0: stay.
- ADD: alu_a=P, alu_b=M, alu_op=OP_ADD; P<=alu_result; next SHIFT.
- SHIFT: alu_a=M, alu_b=1, alu_op=OP_SHL; M<=alu_result; Q<=Q>>1 (internal, no ALU); cnt<=cnt+1. Next: DONE if (Q>>1)==0 or cnt==63; else ADD if Q[1]==1, else SHIFT.
- DONE: product<=P; done=1; busy=1; next IDLE.
- IDLE/DONE ALU drive: alu_a=0, alu_b=0, alu_op=4'b0000.
- Arithmetic modulo 2^WIDTH; bits shifted out of M and carries out of P are discarded, no overflow flag.
- `start` in any state other than IDLE is ignored (not queued).
- ALU `ZERO`/`Is_greater` are not used.

## Timing
- Reset (async, any state): state=IDLE, M=Q=P=0, cnt=0, product=0, busy=0, done=0, ALU drive as IDLE.
- Reset mid-operation aborts; product reads 0 afterwards, no done pulse.
- ALU is combinational; alu_result is consumed in the same cycle the sequencer drives its inputs.
- Latency: start accepted at edge k; done high in the cycle after edge k+N, N = 1 + popcount(op_b) + (msb_index(op_b)+1); N=1 for op_b==0. Maximum N = 1+64+64 = 129.
- `product` updates on the edge ending DONE; visible from the cycle after done, stable until next accepted start completes.
- Back-to-back: start high in the cycle after done is accepted (state is IDLE).
- busy low exactly while state==IDLE.

## Test plan
- op_a=3, op_b=5 -> done 6 cycles after start, product=15; ALU op trace ADD,SHL,SHL,ADD,SHL.
- op_a=0x1234, op_b=0 -> done after 1 cycle, product=0, no ADD/SHL issued.
- op_a=0xFFFF_FFFF_FFFF_FFFF, op_b=2 -> done after 4 cycles, product=0xFFFF_FFFF_FFFF_FFFE (wrap).
- op_a=1, op_b=0x8000_0000_0000_0000 -> done after 66 cycles, product=0x8000_0000_0000_0000; cnt reaches 63 terminating condition.
- op_a=7, op_b=9, start re-pulsed with op_a=1, op_b=1 while busy -> second request ignored, product=63; then start -> product=1 after 3 cycles.
- op_a=5, op_b=0xFF, rst_n low at cycle 4 -> busy=0, done never pulses, product=0, ALU drive zero; post-reset op_a=2, op_b=3 -> product=6.
